input_conditioner: RTL and testbench
====================================

INPUT_CONDITIONER -- requirements
Module: input_conditioner

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 1000000, stable-sample count before a debounced level changes (10 ms at 100 MHz); legal range 1..2^24-1.
REQ-002 SHALL have parameter CHORD_CYCLES, default 5000000, chord collection window length in clk cycles; legal range 1..2^24-1.
REQ-003 SHALL have port clk  input  1  system clock; all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have ports Up, Down, Left, Right  input  1 each  raw asynchronous pushbuttons, active-high.
REQ-006 SHALL have port enable  input  1  high while the game is running; low clears and holds the chord FSM idle.
REQ-007 SHALL have port btn_level  output  4  debounced levels, bit order [3]=Up [2]=Down [1]=Left [0]=Right.
REQ-008 SHALL have port press  output  4  one-cycle rising-edge pulses of btn_level, same bit order.
REQ-009 SHALL have port hit_valid  output  1  one-cycle strobe, hit_code valid.
REQ-010 SHALL have port hit_code  output  5  arrow code per REQ-017.

Function
REQ-011 Each raw button SHALL pass through a 2-flop synchronizer before any other logic.
REQ-012 Per channel: synced value equal to btn_level SHALL clear a 24-bit counter; unequal SHALL increment it; at count DEBOUNCE_CYCLES-1 with inequality, btn_level SHALL take the synced value next edge and counter SHALL clear.
REQ-013 A raw input change held steady SHALL appear on btn_level exactly DEBOUNCE_CYCLES+2 cycles after first sampled; a glitch shorter than DEBOUNCE_CYCLES cycles SHALL never reach btn_level.
REQ-014 press[i] SHALL be high exactly in the first cycle btn_level[i] reads 1; releases SHALL produce no pulse; debounce and press SHALL run regardless of enable.
REQ-015 Chord FSM states: IDLE, COLLECT, EMIT; IDLE with enable high and press!=0 SHALL latch mask=press, clear window counter, go COLLECT.
REQ-016 COLLECT SHALL OR each cycle's press into mask and increment counter; at counter==CHORD_CYCLES-1 SHALL go EMIT; EMIT SHALL drive hit_valid=1 for exactly one cycle, then go IDLE, or COLLECT with mask=press if press!=0 in the EMIT cycle.
REQ-017 hit_code from mask: U=10, D=11, L=12, R=13, UD=14, UL=15, UR=16, DL=17, DR=18, LR=19; three or more bits set SHALL give 20 (ARROW_NONE).
REQ-018 First press in cycle t SHALL yield hit_valid in cycle t+CHORD_CYCLES+1; hit_code SHALL hold 20 whenever hit_valid is low.
REQ-019 A re-press of an already-set direction within the window SHALL not change mask and SHALL not extend the window.
REQ-020 enable falling in any state SHALL return FSM to IDLE next edge with mask cleared and no hit_valid; presses while enable is low SHALL be ignored by the FSM.

Reset
REQ-021 reset high SHALL asynchronously clear synchronizers, counters, btn_level=0, press=0, mask=0, FSM=IDLE, hit_valid=0, hit_code=20.
REQ-022 reset asserted mid-COLLECT or mid-debounce SHALL discard the pending chord/count; buttons held through reset release SHALL re-debounce from zero and produce a press pulse.

Configuration
REQ-023 Macro INPUT_CHORD_EN defined: chord FSM per REQ-015..020.
REQ-024 INPUT_CHORD_EN undefined: no FSM/window counter; hit_valid SHALL pulse the cycle after any press!=0 with enable high, hit_code per REQ-017 from that single cycle's press vector; CHORD_CYCLES ignored.

Verification (DEBOUNCE_CYCLES=4, CHORD_CYCLES=8, INPUT_CHORD_EN defined unless noted)
REQ-025 Up held high from cycle 0 -> btn_level=4'b1000 and press=4'b1000 in cycle 6 only; hit_valid cycle 15, hit_code=10.
REQ-026 Left raw pulses of 3 cycles, repeated with 3-cycle gaps -> btn_level, press, hit_valid stay 0.
REQ-027 press Up at t, Right at t+5 -> single hit_valid at t+9, hit_code=16; Right at t+9 instead -> code 10 at t+9, new window, code 13 at t+18.
REQ-028 Up, Down, Left within one window -> hit_code=20 with hit_valid; enable dropped at t+3 of another window -> no hit_valid.
REQ-029 reset pulsed mid-COLLECT -> all outputs to reset values immediately, no hit_valid afterward until a fresh press.
REQ-030 INPUT_CHORD_EN undefined: Down and Right press pulses same cycle t -> hit_valid at t+1, hit_code=18.

Source files
------------

// File: rtl/input_conditioner.sv
// ============================================================================
// Module   : input_conditioner
// Purpose  : Synchronizes and debounces four pushbuttons, emits press pulses
//            and an arrow hit code. Define INPUT_CHORD_EN to enable the
//            chord-window FSM; otherwise hits are reported per press cycle.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CHORD_CYCLES    = 5000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       Up,
    input  logic       Down,
    input  logic       Left,
    input  logic       Right,
    input  logic       enable,
    output logic [3:0] btn_level,
    output logic [3:0] press,
    output logic       hit_valid,
    output logic [4:0] hit_code
);

    localparam logic [23:0] C_DEB_LAST   = 24'(DEBOUNCE_CYCLES - 1);
    localparam logic [4:0]  C_ARROW_NONE = 5'd20;

    function automatic logic [4:0] arrow_code(input logic [3:0] m);
        logic [4:0] code;
        code = C_ARROW_NONE;
        case (m)
            4'b1000: code = 5'd10;
            4'b0100: code = 5'd11;
            4'b0010: code = 5'd12;
            4'b0001: code = 5'd13;
            4'b1100: code = 5'd14;
            4'b1010: code = 5'd15;
            4'b1001: code = 5'd16;
            4'b0110: code = 5'd17;
            4'b0101: code = 5'd18;
            4'b0011: code = 5'd19;
            default: code = C_ARROW_NONE;
        endcase
        return code;
    endfunction

    logic [3:0] raw_w;
    logic [3:0] sync1_q;
    logic [3:0] sync2_q;
    logic [3:0] level_w;
    logic [3:0] level_d_w;
    logic [3:0] press_q;
    logic [3:0] press_d;

    assign raw_w = {Up, Down, Left, Right};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= raw_w;
            sync2_q <= sync1_q;
        end
    end

    for (genvar i = 0; i < 4; i++) begin : g_chan
        logic [23:0] cnt_q;
        logic [23:0] cnt_d;
        logic        lvl_q;
        logic        lvl_d;

        always_comb begin
            cnt_d = '0;
            lvl_d = lvl_q;
            if (sync2_q[i] != lvl_q) begin
                if (cnt_q == C_DEB_LAST) begin
                    lvl_d = sync2_q[i];
                end else begin
                    cnt_d = cnt_q + 24'd1;
                end
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                cnt_q <= '0;
                lvl_q <= 1'b0;
            end else begin
                cnt_q <= cnt_d;
                lvl_q <= lvl_d;
            end
        end

        assign level_w[i]   = lvl_q;
        assign level_d_w[i] = lvl_d;
    end

    // Registered so the pulse lines up with the first cycle the level reads 1.
    assign press_d = level_d_w & ~level_w;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            press_q <= '0;
        end else begin
            press_q <= press_d;
        end
    end

    assign btn_level = level_w;
    assign press     = press_q;

`ifdef INPUT_CHORD_EN
    localparam logic [23:0] C_WIN_LAST = 24'(CHORD_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_EMIT    = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  mask_q, mask_d;
    logic [23:0] win_q, win_d;
    logic        hit_valid_w;
    logic [4:0]  hit_code_w;

    always_comb begin
        state_d     = state_q;
        mask_d      = mask_q;
        win_d       = win_q;
        hit_valid_w = 1'b0;
        hit_code_w  = C_ARROW_NONE;
        if (!enable) begin
            state_d = S_IDLE;
            mask_d  = '0;
            win_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (press_q != 4'b0000) begin
                        mask_d  = press_q;
                        win_d   = '0;
                        state_d = S_COLLECT;
                    end
                end
                S_COLLECT: begin
                    mask_d = mask_q | press_q;
                    if (win_q == C_WIN_LAST) begin
                        state_d = S_EMIT;
                    end else begin
                        win_d = win_q + 24'd1;
                    end
                end
                S_EMIT: begin
                    hit_valid_w = 1'b1;
                    hit_code_w  = arrow_code(mask_q);
                    win_d       = '0;
                    // A press landing in the emit cycle opens the next window.
                    if (press_q != 4'b0000) begin
                        mask_d  = press_q;
                        state_d = S_COLLECT;
                    end else begin
                        mask_d  = '0;
                        state_d = S_IDLE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    mask_d  = '0;
                    win_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            mask_q  <= '0;
            win_q   <= '0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            win_q   <= win_d;
        end
    end

    assign hit_valid = hit_valid_w;
    assign hit_code  = hit_code_w;
`else
    logic       hit_valid_q, hit_valid_d;
    logic [4:0] hit_code_q, hit_code_d;

    always_comb begin
        hit_valid_d = enable && (press_q != 4'b0000);
        hit_code_d  = hit_valid_d ? arrow_code(press_q) : C_ARROW_NONE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hit_valid_q <= 1'b0;
            hit_code_q  <= C_ARROW_NONE;
        end else begin
            hit_valid_q <= hit_valid_d;
            hit_code_q  <= hit_code_d;
        end
    end

    assign hit_valid = hit_valid_q;
    assign hit_code  = hit_code_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_input_conditioner.sv
// ============================================================================
// Module   : tb_input_conditioner
// Purpose  : Directed self-checking bench for input_conditioner; expectations
//            follow INPUT_CHORD_EN (chord window) or per-press reporting.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_input_conditioner;

    localparam int DEB = 4;
    localparam int CHD = 8;
`ifdef INPUT_CHORD_EN
    localparam bit CHORD_ON = 1'b1;
`else
    localparam bit CHORD_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       Up, Down, Left, Right, enable;
    logic [3:0] btn_level;
    logic [3:0] press;
    logic       hit_valid;
    logic [4:0] hit_code;

    int n_vec  = 0;
    int n_miss = 0;

    input_conditioner #(
        .DEBOUNCE_CYCLES(DEB),
        .CHORD_CYCLES   (CHD)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .Up       (Up),
        .Down     (Down),
        .Left     (Left),
        .Right    (Right),
        .enable   (enable),
        .btn_level(btn_level),
        .press    (press),
        .hit_valid(hit_valid),
        .hit_code (hit_code)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, " level"}, 32'(btn_level), 32'h0);
        check_val({tag, " press"}, 32'(press), 32'h0);
        check_val({tag, " hv"}, 32'(hit_valid), 32'h0);
        check_val({tag, " code"}, 32'(hit_code), 32'd20);
    endtask

    // Leaves the bench in cycle 0: inputs set now are sampled at the next edge.
    task automatic do_reset();
        reset = 1'b1;
        {Up, Down, Left, Right} = 4'b0000;
        enable = 1'b1;
        #1;
        check_reset_outputs("reset");
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Up held from cycle 0: level/press at cycle DEB+2, hit per mode.
    task automatic up_held(input string tag);
        int hv_k;
        hv_k = CHORD_ON ? (DEB + 2 + CHD + 1) : (DEB + 2 + 1);
        for (int k = 1; k <= 16; k++) begin
            Up = 1'b1;
            tick();
            check_val({tag, " level"}, 32'(btn_level), (k >= DEB + 2) ? 32'h8 : 32'h0);
            check_val({tag, " press"}, 32'(press), (k == DEB + 2) ? 32'h8 : 32'h0);
            check_val({tag, " hv"}, 32'(hit_valid), (k == hv_k) ? 32'h1 : 32'h0);
            check_val({tag, " code"}, 32'(hit_code), (k == hv_k) ? 32'd10 : 32'd20);
        end
    endtask

    task automatic run_vec(input string tag, input int n,
                           input int up_at, input int dn_at, input int lf_at,
                           input int rt_at, input int en_off_at,
                           input int h1, input int c1, input int h2, input int c2,
                           input int h3, input int c3);
        logic [3:0] exp_lvl;
        int         exp_code;
        logic       exp_hv;
        for (int c = 0; c < n; c++) begin
            Up     = (up_at >= 0) && (c >= up_at);
            Down   = (dn_at >= 0) && (c >= dn_at);
            Left   = (lf_at >= 0) && (c >= lf_at);
            Right  = (rt_at >= 0) && (c >= rt_at);
            enable = !((en_off_at >= 0) && (c >= en_off_at));
            tick();
            exp_hv   = ((c + 1) == h1) || ((c + 1) == h2) || ((c + 1) == h3);
            exp_code = ((c + 1) == h1) ? c1 : ((c + 1) == h2) ? c2 : ((c + 1) == h3) ? c3 : 20;
            check_val({tag, " hv"}, 32'(exp_hv ? hit_valid : hit_valid), 32'(exp_hv));
            check_val({tag, " code"}, 32'(hit_code), 32'(exp_code));
        end
        exp_lvl[3] = (up_at >= 0) && (n >= up_at + DEB + 2);
        exp_lvl[2] = (dn_at >= 0) && (n >= dn_at + DEB + 2);
        exp_lvl[1] = (lf_at >= 0) && (n >= lf_at + DEB + 2);
        exp_lvl[0] = (rt_at >= 0) && (n >= rt_at + DEB + 2);
        check_val({tag, " final level"}, 32'(btn_level), 32'(exp_lvl));
    endtask

    initial begin
        reset = 1'b0;
        {Up, Down, Left, Right} = 4'b0000;
        enable = 1'b1;
        #2;

        // Single press, then release produces no further pulse or hit.
        do_reset();
        up_held("up_held");
        Up = 1'b0;
        for (int j = 0; j < 10; j++) begin
            tick();
            check_val("release press", 32'(press), 32'h0);
            check_val("release hv", 32'(hit_valid), 32'h0);
        end
        check_val("release level", 32'(btn_level), 32'h0);

        // Glitches of 3 cycles never pass a 4-cycle debounce.
        do_reset();
        for (int c = 0; c < 24; c++) begin
            Left = ((c % 6) < 3);
            tick();
            check_val("glitch level", 32'(btn_level), 32'h0);
            check_val("glitch press", 32'(press), 32'h0);
            check_val("glitch hv", 32'(hit_valid), 32'h0);
        end
        Left = 1'b0;

        do_reset();
        run_vec("up_rt5", 20, 0, -1, -1, 5, -1,
                CHORD_ON ? 15 : 7,  CHORD_ON ? 16 : 10,
                CHORD_ON ? -1 : 12, 13, -1, 20);

        do_reset();
        run_vec("up_rt9", 27, 0, -1, -1, 9, -1,
                CHORD_ON ? 15 : 7,  10,
                CHORD_ON ? 24 : 16, 13, -1, 20);

        do_reset();
        run_vec("udl", 20, 0, 1, 2, -1, -1,
                CHORD_ON ? 15 : 7,  CHORD_ON ? 20 : 10,
                CHORD_ON ? -1 : 8,  11,
                CHORD_ON ? -1 : 9,  12);

        do_reset();
        run_vec("en_drop", 30, 0, 10, -1, -1, 9,
                CHORD_ON ? -1 : 7, 10, -1, 20, -1, 20);

        do_reset();
        run_vec("dn_rt", 18, -1, 0, -1, 0, -1,
                CHORD_ON ? 15 : 7, 18, -1, 20, -1, 20);

        // Reset in the middle of a pending chord; Up stays held throughout.
        do_reset();
        for (int c = 0; c < 10; c++) begin
            Up = 1'b1;
            tick();
        end
        check_val("pre-reset level", 32'(btn_level), 32'h8);
        reset = 1'b1;
        #1;
        check_reset_outputs("mid reset");
        tick();
        tick();
        reset = 1'b0;
        up_held("post_reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

`default_nettype wire
